// File: rtl/dcache_wb_dm_if.sv
// dcache_wb_dm_if
// Bundles the two buses seen by the direct-mapped write-back data cache:
//   - the MEM-stage request bus (mem_address, mem_read, mem_write,
//     mem_byte_enable, mem_wdata in; mem_resp, mem_rdata out)
//   - the 128-bit line bus towards physical memory / L2 (pmem_address,
//     pmem_read, pmem_write, pmem_wdata out; pmem_rdata, pmem_resp in)
// Modports:
//   slave  : the cache's view (receives CPU requests, drives pmem requests)
//   master : the environment's view (pipeline + physical memory)
interface dcache_wb_dm_if;
   logic [15:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_wdata;
   logic         mem_resp;
   logic [15:0]  mem_rdata;

   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  pmem_rdata, pmem_resp,
      output mem_resp, mem_rdata,
      output pmem_address, pmem_read, pmem_write, pmem_wdata
   );

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output pmem_rdata, pmem_resp,
      input  mem_resp, mem_rdata,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata
   );
endinterface

// File: rtl/dcache_wb_dm.sv
// dcache_wb_dm
// Direct-mapped, write-back, write-allocate L1 data cache. Lines are 16 bytes
// (8 x 16-bit words). Hits complete in the request cycle; misses write back a
// dirty victim (if any), fill the line, then the held request hits.
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   reset  : asynchronous active-high; clears valid/dirty bits and the FSM
//   bus    : dcache_wb_dm_if.slave (MEM-stage request bus + 128-bit line bus)
//   hit_count/miss_count/wb_count : 16-bit saturating statistics outputs,
//            present only when DCACHE_STATS_EN is defined
// Parameter:
//   NUM_LINES : number of lines, power of two, at least 2
// Optional feature macro: DCACHE_STATS_EN
module dcache_wb_dm #(
   parameter int NUM_LINES = 8
) (
   input  logic           clk,
   input  logic           reset,
   dcache_wb_dm_if.slave  bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]    hit_count,
   output logic [15:0]    miss_count,
   output logic [15:0]    wb_count
`endif
);

   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = 12 - IW;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_t;

   state_t state;
   state_t next_state;

   logic [127:0]   data_arr [NUM_LINES];
   logic [TW-1:0]  tag_arr  [NUM_LINES];
   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;

   logic [IW-1:0]  req_index;
   logic [TW-1:0]  req_tag;
   logic [2:0]     word_sel;
   logic [6:0]     word_lsb;
   logic           request;
   logic           hit;
   logic           resp_now;
   logic           write_hit;
   logic           fill_done;
   logic           addr_unused;

   // Byte address is split into tag | index | word | byte; the byte bit is
   // never used because all accesses are 16-bit words with byte enables.
   assign req_index   = bus.mem_address[3+IW:4];
   assign req_tag     = bus.mem_address[15:4+IW];
   assign word_sel    = bus.mem_address[3:1];
   assign word_lsb    = {word_sel, 4'b0000};
   assign addr_unused = bus.mem_address[0];

   // A simultaneous read and write strobe is handled as a write, so only
   // mem_write decides whether the hit merges data.
   assign request   = bus.mem_read | bus.mem_write;
   assign hit       = valid[req_index] && (tag_arr[req_index] == req_tag);
   assign resp_now  = (state == IDLE) && request && hit;
   assign write_hit = (state == IDLE) && bus.mem_write && hit;
   assign fill_done = (state == ALLOCATE) && bus.pmem_resp;

   // State register; reset abandons any in-flight line transfer immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A dirty victim always leaves before the new line is
   // fetched, so a same-index conflict can never lose modified data.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (request && !hit) begin
               if (valid[req_index] && dirty[req_index]) begin
                  next_state = WRITEBACK;
               end else begin
                  next_state = ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            if (bus.pmem_resp) begin
               next_state = ALLOCATE;
            end
         end
         ALLOCATE: begin
            if (bus.pmem_resp) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode. The pmem strobes come straight from the state register so
   // they are glitch-free and mutually exclusive; the writeback address is
   // rebuilt from the stored victim tag, the fill address from the request.
   always_comb begin
      bus.mem_resp     = resp_now;
      bus.mem_rdata    = valid[req_index] ? data_arr[req_index][word_lsb +: 16] : 16'h0000;
      bus.pmem_read    = (state == ALLOCATE);
      bus.pmem_write   = (state == WRITEBACK);
      bus.pmem_wdata   = data_arr[req_index];
      bus.pmem_address = 16'h0000;
      case (state)
         WRITEBACK: bus.pmem_address = {tag_arr[req_index], req_index, 4'b0000};
         ALLOCATE:  bus.pmem_address = {req_tag, req_index, 4'b0000};
         default:   bus.pmem_address = 16'h0000;
      endcase
   end

   // Valid and dirty bits. A write hit marks the line dirty even with an
   // all-zero byte mask; a finished writeback cleans it; a fill installs a
   // clean valid line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (write_hit) begin
            dirty[req_index] <= 1'b1;
         end
         if ((state == WRITEBACK) && bus.pmem_resp) begin
            dirty[req_index] <= 1'b0;
         end
         if (fill_done) begin
            valid[req_index] <= 1'b1;
            dirty[req_index] <= 1'b0;
         end
      end
   end

   // Data and tag storage carry no reset; valid gates their use. A fill
   // replaces the whole line, a write hit merges only the enabled bytes.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_arr[req_index] <= bus.pmem_rdata;
         tag_arr[req_index]  <= req_tag;
      end else if (write_hit) begin
         if (bus.mem_byte_enable[0]) begin
            data_arr[req_index][word_lsb +: 8] <= bus.mem_wdata[7:0];
         end
         if (bus.mem_byte_enable[1]) begin
            data_arr[req_index][(word_lsb + 7'd8) +: 8] <= bus.mem_wdata[15:8];
         end
      end
   end

`ifdef DCACHE_STATS_EN
   // Saturating event counters: one hit per completed request, one miss per
   // departure from IDLE, one writeback per completed victim transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= 16'h0000;
         miss_count <= 16'h0000;
         wb_count   <= 16'h0000;
      end else begin
         if (resp_now && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'h0001;
         end
         if ((state == IDLE) && (next_state != IDLE) && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'h0001;
         end
         if ((state == WRITEBACK) && bus.pmem_resp && (wb_count != 16'hFFFF)) begin
            wb_count <= wb_count + 16'h0001;
         end
      end
   end
`endif

endmodule

// File: doc/dcache_wb_dm.md
Name: dcache_wb_dm

Overview:
Direct-mapped, write-back, write-allocate L1 data cache sitting directly downstream of the pipeline's MEM stage. It consumes the D_mem request bus (address, read/write strobes, byte mask, write data) and returns resp/rdata. Misses are serviced over a 128-bit line interface to physical memory (or the L2/arbiter). Lines are 16 bytes (8 x 16-bit words); the index and tag widths are derived from NUM_LINES.

Parameters:
NUM_LINES, 8, number of cache lines; must be a power of 2, minimum 2; index width IW = log2(NUM_LINES), tag width = 12 - IW.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears valid/dirty bits and the FSM
mem_address  input  16  byte address from MEM stage; bit 0 ignored
mem_read  input  1  read request, held stable until mem_resp
mem_write  input  1  write request, held stable until mem_resp
mem_byte_enable  input  2  bit0 = low byte [7:0], bit1 = high byte [15:8]
mem_wdata  input  16  store data
mem_resp  output  1  request complete this cycle
mem_rdata  output  16  word at mem_address[3:1] of the hit line
pmem_address  output  16  line address, low 4 bits = 0
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_wdata  output  128  victim line data
pmem_rdata  input  128  fill data, valid when pmem_resp = 1
pmem_resp  input  1  physical memory completion

Behaviour:
- Address split: offset = addr[3:0], word select = addr[3:1], index = addr[3+IW:4], tag = addr[15:4+IW].
- Arrays: data (NUM_LINES x 128), tag, valid, dirty. Only valid and dirty are reset (to 0); data and tag are not reset.
- Request = mem_read | mem_write. If both are asserted, the request is treated as a write.
- FSM states:
  - IDLE: if request and hit (valid & tag match), mem_resp = 1 combinationally in the same cycle (zero-wait hit). mem_rdata is driven combinationally from the array.
    - Write hit: on that edge, the enabled bytes are merged into the selected word and dirty is set, including when mem_byte_enable = 00.
    - Miss with victim valid & dirty -> WRITEBACK. Miss otherwise -> ALLOCATE.
  - WRITEBACK: pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line. On pmem_resp, clear dirty and go to ALLOCATE.
  - ALLOCATE: pmem_read = 1, pmem_address = {req tag, index, 4'b0}. On pmem_resp, write the line, tag, valid = 1, dirty = 0, then go to IDLE. The held request then hits the next cycle.
- mem_resp is never asserted outside IDLE.
- Miss latency = WB cycles + fill cycles + 1.
- pmem_read and pmem_write are mutually exclusive and are decoded from the state register, so they are glitch-free. They hold steady until pmem_resp.
- Outputs in IDLE with no request: mem_resp = 0, pmem_read = 0, pmem_write = 0, pmem_address = 0, pmem_wdata = don't-care.
- Reset values: state IDLE; all outputs 0 (mem_rdata is 0 only while no line is valid).
- Reset mid-miss: the FSM returns to IDLE asynchronously and pmem strobes drop immediately. No partial line is written and valid/dirty are all cleared, so dirty data is lost by design.
- Request dropped before resp: illegal (the pipeline stalls). Behaviour is undefined, but the FSM still completes any in-flight pmem transaction.
- pmem_resp in IDLE: ignored.
- Same-index conflict: a victim is always written back before its replacement is filled.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds output ports hit_count, miss_count, wb_count (16 bits each, saturating at 16'hFFFF, reset to 0).
  - hit_count increments on each IDLE hit (one per request).
  - miss_count increments on each IDLE -> WRITEBACK/ALLOCATE transition.
  - wb_count increments on each WRITEBACK completion.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x0040 -> miss; ALLOCATE with pmem_address = 0x0040; pmem_rdata = {8{16'hA5A5}} with resp after 3 cycles -> mem_resp 1 cycle later, mem_rdata = 0xA5A5; no pmem_write seen.
- After fill, write 0x0042 = 0x1234 mask 11, then read 0x0042 -> both mem_resp same cycle as request (0 wait), read returns 0x1234.
- Write 0x0044 = 0xBEEF mask 01 over 0xA5A5 -> subsequent read = 0xA5EF; mask 10 with 0x7700 -> read = 0x77EF.
- With NUM_LINES = 8, dirty line at 0x0040, read 0x0240 (same index 4, new tag) -> pmem_write with address 0x0040 and wdata containing 0x1234 at word 1, then pmem_read at 0x0240, then resp.
- Assert reset during ALLOCATE while pmem_resp is pending -> pmem_read = 0 immediately; re-read 0x0042 misses (valid cleared).
- DCACHE_STATS_EN: run the above sequence -> counters match the expected hit/miss/wb totals; force 65536 hits -> hit_count stays at 0xFFFF.
